// File: rtl/npu_dma_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : npu_dma_arbiter
// Description : Round-robin arbiter that shares the single NPU DMA request
//               channel among NUM_REQ requesters. Only one transfer is in
//               flight at a time. The arbiter records which requester owns
//               that transfer and returns the completion pulse to it.
//               Optional feature macro: NPU_DMA_ARB_WDOG_EN enables a
//               watchdog that aborts a WAIT lasting WDOG_CYCLES cycles.
// Ports       : clk, rst_n (async active-low)
//               req_valid/req_src/req_dst/req_bytes -> packed requester slots
//               req_ready (one-hot accept), resp_done (one-hot completion)
//               dma_req_valid/src/dst/bytes, dma_req_ready, dma_resp_done
//               busy, owner, spurious_done, timeout_err, err_clr
// Revision    : 1.0 - initial release
// ============================================================================
module npu_dma_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_W      = 64,
  parameter int LEN_W       = 32,
  parameter int WDOG_CYCLES = 4096
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_src,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_dst,
  input  logic [NUM_REQ*LEN_W-1:0]   req_bytes,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         resp_done,
  output logic                       dma_req_valid,
  output logic [ADDR_W-1:0]          dma_req_src,
  output logic [ADDR_W-1:0]          dma_req_dst,
  output logic [LEN_W-1:0]           dma_req_bytes,
  input  logic                       dma_req_ready,
  input  logic                       dma_resp_done,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       spurious_done,
  output logic                       timeout_err,
  input  logic                       err_clr
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;

  // Round-robin pick: first valid requester at or after rr_ptr, with wrap.
  logic             grant_any;
  logic [IDX_W-1:0] grant_idx;
  always_comb begin
    int idx;
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = IDX_W'(idx);
      end
    end
  end

  logic [ADDR_W-1:0] sel_src;
  logic [ADDR_W-1:0] sel_dst;
  logic [LEN_W-1:0]  sel_bytes;
  assign sel_src   = req_src[int'(grant_idx)*ADDR_W +: ADDR_W];
  assign sel_dst   = req_dst[int'(grant_idx)*ADDR_W +: ADDR_W];
  assign sel_bytes = req_bytes[int'(grant_idx)*LEN_W +: LEN_W];

  // Accept is combinational so the requester sees it in the grant cycle.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && grant_any) req_ready[grant_idx] = 1'b1;
  end

  assign busy = (state != IDLE);

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
    logic [NUM_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(NUM_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  // A completion is only legal in WAIT or together with the ISSUE handshake.
  logic spur_evt;
  assign spur_evt = dma_resp_done &&
                    ((state == IDLE) || (state == ISSUE && !dma_req_ready));

  logic wdog_hit;
`ifdef NPU_DMA_ARB_WDOG_EN
  localparam int CNT_W = $clog2(WDOG_CYCLES + 1);
  logic [CNT_W-1:0] wdog_cnt;

  // Counter is zero outside WAIT, so it starts fresh on every entry.
  // It expires in the WDOG_CYCLES-th WAIT cycle.
  assign wdog_hit = (state == WAIT) && !dma_resp_done &&
                    (wdog_cnt == CNT_W'(WDOG_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state != WAIT) wdog_cnt <= '0;
      else               wdog_cnt <= wdog_cnt + 1'b1;
      if (wdog_hit)     timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
    end
  end
`else
  assign wdog_hit    = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      owner         <= '0;
      resp_done     <= '0;
      dma_req_valid <= 1'b0;
      dma_req_src   <= '0;
      dma_req_dst   <= '0;
      dma_req_bytes <= '0;
      spurious_done <= 1'b0;
    end else begin
      resp_done <= '0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            owner         <= grant_idx;
            dma_req_src   <= sel_src;
            dma_req_dst   <= sel_dst;
            dma_req_bytes <= sel_bytes;
            // Zero-length requests complete without touching the DMA engine.
            if (sel_bytes == '0) begin
              resp_done <= onehot(grant_idx);
              rr_ptr    <= next_ptr(grant_idx);
            end else begin
              state         <= ISSUE;
              dma_req_valid <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (dma_req_ready) begin
            dma_req_valid <= 1'b0;
            if (dma_resp_done) begin
              resp_done <= onehot(owner);
              rr_ptr    <= next_ptr(owner);
              state     <= IDLE;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (dma_resp_done || wdog_hit) begin
            resp_done <= onehot(owner);
            rr_ptr    <= next_ptr(owner);
            state     <= IDLE;
          end
        end
        default: begin
          state         <= IDLE;
          dma_req_valid <= 1'b0;
        end
      endcase

      // A new error event wins over a simultaneous clear.
      if (spur_evt)     spurious_done <= 1'b1;
      else if (err_clr) spurious_done <= 1'b0;
    end
  end

endmodule
`default_nettype wire
